// File: rtl/dpc_pkg.sv
// Shared helpers for the DPC pipeline: window indexing and delta widths.
package dpc_pkg;

  localparam int DW_DEF      = 8;
  localparam int WIN_DEF     = 3;
  localparam int DELTA_W_DEF = DW_DEF + 1;

  // Signed centre-minus-neighbour delta needs one extra bit over the pixel.
  function automatic int delta_w(input int dw);
    return dw + 1;
  endfunction

  // Row-major element index inside a WIN x WIN window.
  function automatic int pix_idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

  function automatic int center_idx(input int win);
    return pix_idx(win / 2, win / 2, win);
  endfunction

endpackage

// File: rtl/delta_minmax_tree.sv
// Combinational signed min/max over M packed W-bit values, pairwise tree.
// Leaves beyond M are padded with element 0 so they never change the result.
module delta_minmax_tree #(
  parameter int M = 8,
  parameter int W = 9
) (
  input  logic [M*W-1:0] d,
  output logic [W-1:0]   dmin,
  output logic [W-1:0]   dmax
);

  localparam int L = (M > 1) ? $clog2(M) : 1;
  localparam int P = 1 << L;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CNT = P >> l;
    logic signed [W-1:0] mn [CNT];
    logic signed [W-1:0] mx [CNT];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < CNT; i++) begin : g_in
        localparam int SRC = (i < M) ? i : 0;
        assign mn[i] = $signed(d[SRC*W +: W]);
        assign mx[i] = $signed(d[SRC*W +: W]);
      end
    end else begin : g_node
      for (genvar i = 0; i < CNT; i++) begin : g_pair
        assign mn[i] = (g_lvl[l-1].mn[2*i] < g_lvl[l-1].mn[2*i+1]) ?
                       g_lvl[l-1].mn[2*i] : g_lvl[l-1].mn[2*i+1];
        assign mx[i] = (g_lvl[l-1].mx[2*i] > g_lvl[l-1].mx[2*i+1]) ?
                       g_lvl[l-1].mx[2*i] : g_lvl[l-1].mx[2*i+1];
      end
    end
  end

  assign dmin = g_lvl[L].mn[0];
  assign dmax = g_lvl[L].mx[0];

endmodule

// File: rtl/dpc_delta_win.sv
// Centre-minus-neighbour delta engine for defect pixel correction.
// Three register stages: capture window, subtract, reduce/flag.
module dpc_delta_win
  import dpc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int WIN = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_valid,
  input  logic                              i_sof,
  input  logic                              i_eol,
  input  logic [WIN*WIN*DW-1:0]             i_win,
  input  logic [DW-1:0]                     i_thresh,
  output logic                              o_valid,
  output logic                              o_sof,
  output logic                              o_eol,
  output logic [WIN*WIN*delta_w(DW)-1:0]    o_delta,
  output logic [DW-1:0]                     o_center,
  output logic [delta_w(DW)-1:0]            o_dmin,
  output logic [delta_w(DW)-1:0]            o_dmax,
  output logic                              o_hot,
  output logic                              o_cold
);

  localparam int N   = WIN * WIN;
  localparam int C   = center_idx(WIN);
  localparam int DLW = delta_w(DW);
  localparam int NB  = N - 1;

  logic [2:0]              v;
  logic [N*DW-1:0]         win1;
  logic [DW-1:0]           thr1;
  logic                    sof1, eol1;
  logic [N*DLW-1:0]        delta_c;
  logic [N*DLW-1:0]        delta2;
  logic [DW-1:0]           cen2, thr2;
  logic                    sof2, eol2;
  logic [NB*DLW-1:0]       nbr;
  logic [NB-1:0]           hot_t, cold_t;
  logic [DLW-1:0]          dmin_c, dmax_c;
  logic signed [DLW-1:0]   pos_thr, neg_thr;

  // Valid pipe; o_valid is the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) v <= '0;
    else          v <= {v[1:0], i_valid};
  end

  assign o_valid = v[2];

  // S1: capture window and threshold together so a threshold change applies to its own window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win1 <= '0;
      thr1 <= '0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
    end else begin
      sof1 <= i_valid & i_sof;
      eol1 <= i_valid & i_eol;
      if (i_valid) begin
        win1 <= i_win;
        thr1 <= i_thresh;
      end
    end
  end

  // Zero-extended subtraction cannot overflow the DW+1 result; centre slot carries the pixel.
  for (genvar k = 0; k < N; k++) begin : g_sub
    if (k == C) begin : g_ctr
      assign delta_c[k*DLW +: DLW] = {1'b0, win1[C*DW +: DW]};
    end else begin : g_nb
      assign delta_c[k*DLW +: DLW] = {1'b0, win1[C*DW +: DW]} - {1'b0, win1[k*DW +: DW]};
    end
  end

  // S2: register deltas and carry centre/threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delta2 <= '0;
      cen2   <= '0;
      thr2   <= '0;
      sof2   <= 1'b0;
      eol2   <= 1'b0;
    end else begin
      sof2 <= v[0] & sof1;
      eol2 <= v[0] & eol1;
      if (v[0]) begin
        delta2 <= delta_c;
        cen2   <= win1[C*DW +: DW];
        thr2   <= thr1;
      end
    end
  end

  assign pos_thr = $signed({1'b0, thr2});
  assign neg_thr = -pos_thr;

  // Neighbour-only view of the deltas plus per-slot flag terms.
  for (genvar k = 0; k < N; k++) begin : g_nbr
    if (k != C) begin : g_use
      localparam int J = (k < C) ? k : k - 1;
      assign nbr[J*DLW +: DLW] = delta2[k*DLW +: DLW];
      assign hot_t[J]  = $signed(delta2[k*DLW +: DLW]) > pos_thr;
      assign cold_t[J] = $signed(delta2[k*DLW +: DLW]) < neg_thr;
    end
  end

  delta_minmax_tree #(
    .M (NB),
    .W (DLW)
  ) u_tree (
    .d    (nbr),
    .dmin (dmin_c),
    .dmax (dmax_c)
  );

  // S3: register results; data holds while no window is present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_delta  <= '0;
      o_center <= '0;
      o_dmin   <= '0;
      o_dmax   <= '0;
      o_hot    <= 1'b0;
      o_cold   <= 1'b0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
    end else begin
      o_sof <= v[1] & sof2;
      o_eol <= v[1] & eol2;
      if (v[1]) begin
        o_delta  <= delta2;
        o_center <= cen2;
        o_dmin   <= dmin_c;
        o_dmax   <= dmax_c;
        o_hot    <= &hot_t;
        o_cold   <= &cold_t;
      end
    end
  end

endmodule

// File: tb/tb_dpc_delta_win.sv
// Self-checking bench for dpc_delta_win at (DW=8,WIN=3) and (DW=12,WIN=5).
module tb_dpc_delta_win;

  typedef struct {
    bit v;
    bit sof;
    bit eol;
    int thr;
    int pix[25];
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic         a_valid = 0, a_sof = 0, a_eol = 0;
  logic [71:0]  a_win = '0;
  logic [7:0]   a_thr = '0;
  logic         a_ov, a_osof, a_oeol, a_hot, a_cold;
  logic [80:0]  a_delta;
  logic [7:0]   a_center;
  logic [8:0]   a_dmin, a_dmax;

  logic         b_valid = 0, b_sof = 0, b_eol = 0;
  logic [299:0] b_win = '0;
  logic [11:0]  b_thr = '0;
  logic         b_ov, b_osof, b_oeol, b_hot, b_cold;
  logic [324:0] b_delta;
  logic [11:0]  b_center;
  logic [12:0]  b_dmin, b_dmax;

  dpc_delta_win #(.DW(8), .WIN(3)) u_a (
    .clk(clk), .reset_n(reset_n), .i_valid(a_valid), .i_sof(a_sof), .i_eol(a_eol),
    .i_win(a_win), .i_thresh(a_thr), .o_valid(a_ov), .o_sof(a_osof), .o_eol(a_oeol),
    .o_delta(a_delta), .o_center(a_center), .o_dmin(a_dmin), .o_dmax(a_dmax),
    .o_hot(a_hot), .o_cold(a_cold));

  dpc_delta_win #(.DW(12), .WIN(5)) u_b (
    .clk(clk), .reset_n(reset_n), .i_valid(b_valid), .i_sof(b_sof), .i_eol(b_eol),
    .i_win(b_win), .i_thresh(b_thr), .o_valid(b_ov), .o_sof(b_osof), .o_eol(b_oeol),
    .o_delta(b_delta), .o_center(b_center), .o_dmin(b_dmin), .o_dmax(b_dmax),
    .o_hot(b_hot), .o_cold(b_cold));

  // Reference model: plain integer arithmetic over the window.
  function automatic void model(input int pix[25], input int thr, input int win, input int dw,
                                output logic [324:0] dl, output int mn, output int mx,
                                output bit hot, output bit cold);
    int n = win * win;
    int c = n / 2;
    int d, val;
    dl = '0; mn = 1 << 30; mx = -(1 << 30); hot = 1; cold = 1;
    for (int k = 0; k < n; k++) begin
      d = pix[c] - pix[k];
      val = (k == c) ? pix[c] : d;
      for (int b = 0; b <= dw; b++) dl[k*(dw+1)+b] = val[b];
      if (k != c) begin
        if (d < mn) mn = d;
        if (d > mx) mx = d;
        if (!(d > thr)) hot = 0;
        if (!(d < -thr)) cold = 0;
      end
    end
  endfunction

  function automatic void fill(inout rec_t r, input int win, input int dw);
    int maxv = (1 << dw) - 1;
    int m = $urandom_range(0, 3);
    int c = (win * win) / 2;
    for (int k = 0; k < win * win; k++) begin
      if (m == 2) r.pix[k] = (k == c) ? $urandom_range(maxv - 40, maxv) : $urandom_range(0, maxv / 2);
      else if (m == 3) r.pix[k] = (k == c) ? $urandom_range(0, 40) : $urandom_range(maxv / 2, maxv);
      else r.pix[k] = $urandom_range(0, maxv);
    end
    r.thr = (m >= 2) ? $urandom_range(0, maxv / 2) : $urandom_range(0, maxv);
  endfunction

  task automatic drive_a(input rec_t r);
    a_valid = r.v; a_sof = r.sof; a_eol = r.eol; a_thr = 8'(r.thr);
    for (int k = 0; k < 9; k++) a_win[k*8 +: 8] = 8'(r.pix[k]);
  endtask

  task automatic drive_b(input rec_t r);
    b_valid = r.v; b_sof = r.sof; b_eol = r.eol; b_thr = 12'(r.thr);
    for (int k = 0; k < 25; k++) b_win[k*12 +: 12] = 12'(r.pix[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; a_valid = 0; b_valid = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({a_ov, a_osof, a_oeol, a_hot, a_cold} !== 5'b0) begin errors++; $display("FAIL reset_a_ctrl: got %b expected 00000", {a_ov, a_osof, a_oeol, a_hot, a_cold}); end
    checks++; if ({a_delta, a_center, a_dmin, a_dmax} !== '0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", {a_delta, a_center, a_dmin, a_dmax}); end
    checks++; if ({b_ov, b_osof, b_oeol, b_hot, b_cold} !== 5'b0) begin errors++; $display("FAIL reset_b_ctrl: got %b expected 00000", {b_ov, b_osof, b_oeol, b_hot, b_cold}); end
    checks++; if ({b_delta, b_center, b_dmin, b_dmax} !== '0) begin errors++; $display("FAIL reset_b_data: got %h expected 0", {b_delta, b_center, b_dmin, b_dmax}); end
  endtask

  task automatic test_flat();
    rec_t r;
    logic [80:0] e = '0;
    e[36 +: 9] = 9'd100;
    r.v = 1; r.sof = 0; r.eol = 0; r.thr = 0;
    for (int k = 0; k < 25; k++) r.pix[k] = 100;
    do_reset();
    drive_a(r);
    @(negedge clk); a_valid = 0;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL flat_early_valid: got %b expected 0", a_ov); end
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL flat_valid: got %b expected 1", a_ov); end
    checks++; if (a_delta !== e) begin errors++; $display("FAIL flat_delta: got %h expected %h", a_delta, e); end
    checks++; if (a_center !== 8'd100) begin errors++; $display("FAIL flat_center: got %0d expected 100", a_center); end
    checks++; if ({a_dmin, a_dmax} !== 18'd0) begin errors++; $display("FAIL flat_minmax: got %h %h expected 0 0", a_dmin, a_dmax); end
    checks++; if ({a_hot, a_cold} !== 2'b00) begin errors++; $display("FAIL flat_flags: got %b expected 00", {a_hot, a_cold}); end
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL flat_single_pulse: got %b expected 0", a_ov); end
    checks++; if (a_delta !== e) begin errors++; $display("FAIL flat_hold: got %h expected %h", a_delta, e); end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    logic [80:0] e = '0;
    int j;
    r.v = 1; r.sof = 0; r.eol = 0;
    for (int k = 0; k < 25; k++) r.pix[k] = 0;
    for (int k = 0; k < 9; k++) begin
      j = (k < 4) ? k : k - 1;
      r.pix[k] = (k == 4) ? 255 : j;
      e[k*9 +: 9] = (k == 4) ? 9'd255 : 9'(255 - j);
    end
    @(negedge clk); r.thr = 200; drive_a(r);
    @(negedge clk); r.thr = 250; drive_a(r);
    @(negedge clk); a_valid = 0;
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %b expected 1", a_ov); end
    checks++; if (a_delta !== e) begin errors++; $display("FAIL b2b_delta: got %h expected %h", a_delta, e); end
    checks++; if (a_dmin !== 9'd248 || a_dmax !== 9'd255) begin errors++; $display("FAIL b2b_minmax: got %0d %0d expected 248 255", a_dmin, a_dmax); end
    checks++; if ({a_hot, a_cold} !== 2'b10) begin errors++; $display("FAIL b2b_hot_200: got %b expected 10", {a_hot, a_cold}); end
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", a_ov); end
    checks++; if ({a_hot, a_cold} !== 2'b00) begin errors++; $display("FAIL b2b_hot_250: got %b expected 00", {a_hot, a_cold}); end
  endtask

  task automatic test_cold_extremes();
    rec_t r [3];
    logic [8:0] nb [3];
    logic [8:0] cs [3];
    logic [1:0] fl [3];
    logic [80:0] e;
    r[0].thr = 20;  nb[0] = 9'h1E2; cs[0] = 9'd0;   fl[0] = 2'b01;
    r[1].thr = 0;   nb[1] = 9'h101; cs[1] = 9'd0;   fl[1] = 2'b01;
    r[2].thr = 254; nb[2] = 9'h0FF; cs[2] = 9'd255; fl[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      r[i].v = 1; r[i].sof = 0; r[i].eol = 0;
      for (int k = 0; k < 25; k++) r[i].pix[k] = (i == 0) ? 30 : (i == 1) ? 255 : 0;
      r[i].pix[4] = (i == 2) ? 255 : 0;
    end
    for (int i = 0; i < 3; i++) begin @(negedge clk); drive_a(r[i]); end
    @(negedge clk); a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      e = '0;
      for (int k = 0; k < 9; k++) e[k*9 +: 9] = (k == 4) ? cs[i] : nb[i];
      checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL cold_valid[%0d]: got %b expected 1", i, a_ov); end
      checks++; if (a_delta !== e) begin errors++; $display("FAIL cold_delta[%0d]: got %h expected %h", i, a_delta, e); end
      checks++; if (a_dmin !== nb[i] || a_dmax !== nb[i]) begin errors++; $display("FAIL cold_minmax[%0d]: got %h %h expected %h", i, a_dmin, a_dmax, nb[i]); end
      checks++; if ({a_hot, a_cold} !== fl[i]) begin errors++; $display("FAIL cold_flags[%0d]: got %b expected %b", i, {a_hot, a_cold}, fl[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    rec_t r;
    r.v = 1; r.sof = 1; r.eol = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fill(r, 3, 8); r.pix[4] = 255; r.thr = 0; drive_a(r);
    end
    @(negedge clk); a_valid = 0;
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", a_ov); end
    reset_n = 0;
    #1;
    checks++; if ({a_ov, a_osof, a_oeol, a_hot, a_cold} !== 5'b0) begin errors++; $display("FAIL mid_ctrl: got %b expected 00000", {a_ov, a_osof, a_oeol, a_hot, a_cold}); end
    checks++; if ({a_delta, a_center, a_dmin, a_dmax} !== '0) begin errors++; $display("FAIL mid_data: got %h expected 0", {a_delta, a_center, a_dmin, a_dmax}); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (a_ov !== 1'b0 || a_delta !== '0) begin errors++; $display("FAIL mid_ghost[%0d]: got valid=%b delta=%h expected 0", i, a_ov, a_delta); end
    end
    fill(r, 3, 8); r.sof = 0; r.eol = 0; drive_a(r);
    @(negedge clk); a_valid = 0;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_post_early: got %b expected 0", a_ov); end
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL mid_post_valid: got %b expected 1", a_ov); end
  endtask

  task automatic test_random_win3();
    rec_t hist[3];
    rec_t nr;
    int nv = 0, drain = 0, cyc = 0, mn, mx;
    logic [324:0] dl;
    bit hh, cc, ev;
    logic [80:0] ed = '0;
    logic [8:0] emn = '0, emx = '0;
    logic [7:0] ec = '0;
    bit eh = 0, eco = 0;
    for (int i = 0; i < 3; i++) begin hist[i].v = 0; hist[i].sof = 0; hist[i].eol = 0; end
    do_reset();
    while (drain < 4 && cyc < 6000) begin
      @(negedge clk); cyc++;
      ev = hist[2].v;
      if (ev) begin
        model(hist[2].pix, hist[2].thr, 3, 8, dl, mn, mx, hh, cc);
        ed = dl[80:0]; emn = 9'(mn); emx = 9'(mx); ec = 8'(hist[2].pix[4]); eh = hh; eco = cc;
      end
      checks++; if (a_ov !== ev) begin errors++; $display("FAIL r3_valid cyc %0d: got %b expected %b", cyc, a_ov, ev); end
      checks++; if ({a_osof, a_oeol} !== {ev & hist[2].sof, ev & hist[2].eol}) begin errors++; $display("FAIL r3_side cyc %0d: got %b expected %b", cyc, {a_osof, a_oeol}, {ev & hist[2].sof, ev & hist[2].eol}); end
      checks++; if (a_delta !== ed || a_center !== ec) begin errors++; $display("FAIL r3_delta cyc %0d: got %h/%h expected %h/%h", cyc, a_delta, a_center, ed, ec); end
      checks++; if (a_dmin !== emn || a_dmax !== emx) begin errors++; $display("FAIL r3_minmax cyc %0d: got %h %h expected %h %h", cyc, a_dmin, a_dmax, emn, emx); end
      checks++; if ({a_hot, a_cold} !== {eh, eco}) begin errors++; $display("FAIL r3_flags cyc %0d: got %b expected %b", cyc, {a_hot, a_cold}, {eh, eco}); end
      fill(nr, 3, 8);
      if (nv < 1000) nr.v = ($urandom_range(0, 99) < 60);
      else begin nr.v = 0; drain++; end
      if (nr.v) begin nr.sof = (nv == 0); nr.eol = ((nv % 64) == 63); nv++; end
      else begin nr.sof = 1'($urandom_range(0, 1)); nr.eol = 1'($urandom_range(0, 1)); end
      drive_a(nr);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nr;
    end
    checks++; if (drain < 4) begin errors++; $display("FAIL r3_timeout: got %0d cycles expected completion", cyc); end
    a_valid = 0;
  endtask

  task automatic test_random_win5();
    rec_t hist[3];
    rec_t nr;
    int nv = 0, drain = 0, cyc = 0, mn, mx;
    logic [324:0] dl;
    bit hh, cc, ev;
    logic [324:0] ed = '0;
    logic [12:0] emn = '0, emx = '0;
    logic [11:0] ec = '0;
    bit eh = 0, eco = 0;
    for (int i = 0; i < 3; i++) begin hist[i].v = 0; hist[i].sof = 0; hist[i].eol = 0; end
    do_reset();
    while (drain < 4 && cyc < 3000) begin
      @(negedge clk); cyc++;
      ev = hist[2].v;
      if (ev) begin
        model(hist[2].pix, hist[2].thr, 5, 12, dl, mn, mx, hh, cc);
        ed = dl; emn = 13'(mn); emx = 13'(mx); ec = 12'(hist[2].pix[12]); eh = hh; eco = cc;
      end
      checks++; if (b_ov !== ev) begin errors++; $display("FAIL r5_valid cyc %0d: got %b expected %b", cyc, b_ov, ev); end
      checks++; if ({b_osof, b_oeol} !== {ev & hist[2].sof, ev & hist[2].eol}) begin errors++; $display("FAIL r5_side cyc %0d: got %b expected %b", cyc, {b_osof, b_oeol}, {ev & hist[2].sof, ev & hist[2].eol}); end
      checks++; if (b_delta !== ed || b_center !== ec) begin errors++; $display("FAIL r5_delta cyc %0d: got %h/%h expected %h/%h", cyc, b_delta, b_center, ed, ec); end
      checks++; if (b_dmin !== emn || b_dmax !== emx) begin errors++; $display("FAIL r5_minmax cyc %0d: got %h %h expected %h %h", cyc, b_dmin, b_dmax, emn, emx); end
      checks++; if ({b_hot, b_cold} !== {eh, eco}) begin errors++; $display("FAIL r5_flags cyc %0d: got %b expected %b", cyc, {b_hot, b_cold}, {eh, eco}); end
      fill(nr, 5, 12);
      if (nv < 300) nr.v = ($urandom_range(0, 99) < 60);
      else begin nr.v = 0; drain++; end
      if (nr.v) begin nr.sof = (nv == 0); nr.eol = ((nv % 64) == 63); nv++; end
      else begin nr.sof = 1'($urandom_range(0, 1)); nr.eol = 1'($urandom_range(0, 1)); end
      drive_b(nr);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nr;
    end
    checks++; if (drain < 4) begin errors++; $display("FAIL r5_timeout: got %0d cycles expected completion", cyc); end
    b_valid = 0;
  endtask

  initial begin
    test_reset();
    test_flat();
    test_back_to_back();
    test_cold_extremes();
    test_reset_midstream();
    test_random_win3();
    test_random_win5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
